watch_time_counter: RTL and testbench

Consumer of the periodic tick the watch datapath already produces: accumulates single-cycle `i_tick` pulses into sub-second, second, minute and hour fields with run/stop control, clear, and per-field manual set. It sits between the tick source and the display/UART formatting logic and is the single owner of watch time state.

---
 rtl/watch_time_counter.sv | 139 +++++++++++++
 tb/tb_watch_time_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/watch_time_counter.sv
// Watch time-of-day counter: accumulates time-base ticks into subsec/sec/min/hour
// fields, with run/stop control, clear and per-field manual set while stopped.
module watch_time_counter #(
    parameter int unsigned TICK_FREQ = 100,
    parameter int unsigned HOUR_MAX  = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_tick,
    input  logic                          i_run_stop,
    input  logic                          i_clear,
    input  logic                          i_inc_sec,
    input  logic                          i_inc_min,
    input  logic                          i_inc_hour,
    output logic [$clog2(TICK_FREQ)-1:0]  o_subsec,
    output logic [5:0]                    o_sec,
    output logic [5:0]                    o_min,
    output logic [$clog2(HOUR_MAX)-1:0]   o_hour,
    output logic                          o_running,
    output logic                          o_day_pulse
);

    localparam int unsigned SUB_W  = $clog2(TICK_FREQ);
    localparam int unsigned HOUR_W = $clog2(HOUR_MAX);
    localparam int unsigned MS_W   = 6;
    localparam int unsigned MS_MAX = 59;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SUB_W-1:0]    subsec_q, subsec_d;
    logic [MS_W-1:0]     sec_q, sec_d;
    logic [MS_W-1:0]     min_q, min_d;
    logic [HOUR_W-1:0]   hour_q, hour_d;
    logic                running_q;
    logic                day_q, day_d;

    logic                subsec_wrap;
    logic                sec_wrap;
    logic                min_wrap;
    logic                hour_wrap;

    // Terminal-count detection shared by tick ripple and manual increments
    assign subsec_wrap = (subsec_q == SUB_W'(TICK_FREQ - 1));
    assign sec_wrap    = (sec_q    == MS_W'(MS_MAX));
    assign min_wrap    = (min_q    == MS_W'(MS_MAX));
    assign hour_wrap   = (hour_q   == HOUR_W'(HOUR_MAX - 1));

    // State register and all output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= STOP;
            subsec_q  <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            running_q <= 1'b0;
            day_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            subsec_q  <= subsec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            running_q <= (state_d == RUN);
            day_q     <= day_d;
        end
    end

    // Next-state and next-field logic
    always_comb begin
        state_d  = state_q;
        subsec_d = subsec_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        day_d    = 1'b0;

        case (state_q)
            STOP: begin
                if (i_clear) begin
                    // Clear wins over increments and swallows a coincident run command
                    subsec_d = '0;
                    sec_d    = '0;
                    min_d    = '0;
                    hour_d   = '0;
                end else begin
                    if (i_inc_sec) begin
                        sec_d = sec_wrap ? '0 : sec_q + MS_W'(1);
                    end
                    if (i_inc_min) begin
                        min_d = min_wrap ? '0 : min_q + MS_W'(1);
                    end
                    if (i_inc_hour) begin
                        hour_d = hour_wrap ? '0 : hour_q + HOUR_W'(1);
                    end
                    if (i_run_stop) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (i_tick) begin
                    // Single-cycle carry ripple across all fields
                    subsec_d = subsec_wrap ? '0 : subsec_q + SUB_W'(1);
                    if (subsec_wrap) begin
                        sec_d = sec_wrap ? '0 : sec_q + MS_W'(1);
                        if (sec_wrap) begin
                            min_d = min_wrap ? '0 : min_q + MS_W'(1);
                            if (min_wrap) begin
                                hour_d = hour_wrap ? '0 : hour_q + HOUR_W'(1);
                                day_d  = hour_wrap;
                            end
                        end
                    end
                end
                if (i_run_stop) begin
                    state_d = STOP;
                end
            end

            default: begin
                state_d = STOP;
            end
        endcase
    end

    assign o_subsec    = subsec_q;
    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_hour      = hour_q;
    assign o_running   = running_q;
    assign o_day_pulse = day_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Self-checking bench for watch_time_counter: directed scenarios plus random
// commands, compared against a total-ticks reference model.
module tb_watch_time_counter;

    localparam int unsigned TF     = 100;
    localparam int unsigned HM     = 24;
    localparam int unsigned DAY_TK = TF * 60 * 60 * HM;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_run_stop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_inc_sec = 1'b0;
    logic       i_inc_min = 1'b0;
    logic       i_inc_hour = 1'b0;
    logic [$clog2(TF)-1:0] o_subsec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [$clog2(HM)-1:0] o_hour;
    logic       o_running;
    logic       o_day_pulse;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int  m_ss, m_s, m_m, m_h;
    bit  m_run, m_day;

    watch_time_counter #(.TICK_FREQ(TF), .HOUR_MAX(HM)) dut (
        .clk(clk), .reset(reset), .i_tick(i_tick), .i_run_stop(i_run_stop),
        .i_clear(i_clear), .i_inc_sec(i_inc_sec), .i_inc_min(i_inc_min),
        .i_inc_hour(i_inc_hour), .o_subsec(o_subsec), .o_sec(o_sec),
        .o_min(o_min), .o_hour(o_hour), .o_running(o_running),
        .o_day_pulse(o_day_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".subsec"}, int'(o_subsec), m_ss);
        check({tag, ".sec"}, int'(o_sec), m_s);
        check({tag, ".min"}, int'(o_min), m_m);
        check({tag, ".hour"}, int'(o_hour), m_h);
        check({tag, ".running"}, int'(o_running), int'(m_run));
        check({tag, ".day"}, int'(o_day_pulse), int'(m_day));
    endtask

    task automatic model_reset();
        m_ss = 0; m_s = 0; m_m = 0; m_h = 0; m_run = 0; m_day = 0;
    endtask

    task automatic model_apply(input bit tk, input bit rs, input bit clr,
                               input bit is, input bit im, input bit ih);
        int total;
        m_day = 0;
        if (m_run) begin
            if (tk) begin
                total = ((m_h * 60 + m_m) * 60 + m_s) * TF + m_ss + 1;
                if (total == DAY_TK) begin
                    total = 0;
                    m_day = 1;
                end
                m_ss = total % TF;
                m_s  = (total / TF) % 60;
                m_m  = (total / (TF * 60)) % 60;
                m_h  = total / (TF * 3600);
            end
            if (rs) m_run = 0;
        end else if (clr) begin
            m_ss = 0; m_s = 0; m_m = 0; m_h = 0;
        end else begin
            if (is) m_s = (m_s + 1) % 60;
            if (im) m_m = (m_m + 1) % 60;
            if (ih) m_h = (m_h + 1) % HM;
            if (rs) m_run = 1;
        end
    endtask

    // Apply one cycle of inputs, advance the model, check every output
    task automatic cycle(input string tag, input bit tk, input bit rs, input bit clr,
                         input bit is, input bit im, input bit ih);
        i_tick = tk; i_run_stop = rs; i_clear = clr;
        i_inc_sec = is; i_inc_min = im; i_inc_hour = ih;
        @(posedge clk);
        #1;
        model_apply(tk, rs, clr, is, im, ih);
        i_tick = 0; i_run_stop = 0; i_clear = 0;
        i_inc_sec = 0; i_inc_min = 0; i_inc_hour = 0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // One second of ticks after starting
        cycle("start", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) cycle("tick1s", 1, 0, 0, 0, 0, 0);
        check("plan1.sec", int'(o_sec), 1);
        check("plan1.subsec", int'(o_subsec), 0);
        check("plan1.running", int'(o_running), 1);

        // Ticks while stopped are ignored
        cycle("stop", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("stoptick", 1, 0, 0, 0, 0, 0);
        check("stoptick.sec", int'(o_sec), 1);

        // Set 23:59:59 with simultaneous increments, then roll over the day
        cycle("clr", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 59; i++) cycle("set", 0, 0, 0, 1, 1, i < 23);
        check("set.hour", int'(o_hour), 23);
        check("set.min", int'(o_min), 59);
        cycle("run2", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 99; i++) cycle("tick99", 1, 0, 0, 0, 0, 0);
        check("pre.subsec", int'(o_subsec), 99);
        cycle("rollover", 1, 0, 0, 0, 0, 0);
        check("roll.day", int'(o_day_pulse), 1);
        check("roll.hour", int'(o_hour), 0);
        cycle("after", 0, 0, 0, 0, 0, 0);
        check("after.day", int'(o_day_pulse), 0);

        // Manual minute increments do not carry; clear beats increment
        cycle("stop3", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 61; i++) cycle("incmin", 0, 0, 0, 0, 1, 0);
        check("incmin.min", int'(o_min), 1);
        check("incmin.hour", int'(o_hour), 0);
        cycle("clr_inc", 0, 0, 1, 1, 0, 0);
        check("clr_inc.sec", int'(o_sec), 0);

        // Clear with run command stays stopped; increment with run starts
        cycle("clr_rs", 0, 1, 1, 0, 0, 0);
        check("clr_rs.running", int'(o_running), 0);
        cycle("inc_rs", 0, 1, 0, 1, 0, 0);
        check("inc_rs.running", int'(o_running), 1);

        // Tick together with stop is still counted
        for (int i = 0; i < 5; i++) cycle("tick5", 1, 0, 0, 0, 0, 0);
        cycle("tick_rs", 1, 1, 0, 0, 0, 0);
        check("tick_rs.subsec", int'(o_subsec), 6);
        check("tick_rs.running", int'(o_running), 0);
        cycle("tick_ign", 1, 0, 0, 0, 0, 0);
        check("tick_ign.subsec", int'(o_subsec), 6);

        // Random commands
        for (int i = 0; i < 3000; i++) begin
            cycle("rand", $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset between edges
        if (!m_run) cycle("rerun", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle("pre_rst", 1, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        cycle("post_rst", 1, 0, 0, 0, 0, 0);
        check("post_rst.running", int'(o_running), 0);
        cycle("post_rst_inc", 0, 0, 0, 0, 0, 1);
        check("post_rst.hour", int'(o_hour), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
